int_to_fp_converter: RTL and testbench

//  Pipelined integer-to-IEEE-754 single-precision converter with valid/ready handshake.

---
 rtl/int_to_fp_converter.sv | 173 +++++++++++++++++
 tb/tb_int_to_fp_converter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_to_fp_converter.sv
// Integer to IEEE-754 single-precision converter.
// Three register stages: absolute value, normalise, round and pack.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// The whole pipeline advances only when the output register is empty or being
// consumed; in_ready is that same advance signal, so a stalled output freezes
// every stage and the held result stays stable until it is taken.
module int_to_fp_converter #(
    parameter int INT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INT_W-1:0] int_in,
    input  logic             is_signed,
    input  logic [1:0]       round_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      FP_out,
    output logic             inexact,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int LZW = $clog2(INT_W + 1);

    localparam logic [1:0] RM_RNE  = 2'b00;
    localparam logic [1:0] RM_RTZ  = 2'b01;
    localparam logic [1:0] RM_POS  = 2'b10;
    localparam logic [1:0] RM_NEG  = 2'b11;

    logic adv;

    // Stage 1 registers: sign, magnitude, rounding mode
    logic             s1_valid_q;
    logic             s1_sign_q,  s1_sign_d;
    logic [INT_W-1:0] s1_mag_q,   s1_mag_d;
    logic [1:0]       s1_rm_q;

    // Stage 2 registers: normalised magnitude and biased exponent
    logic             s2_valid_q;
    logic             s2_sign_q;
    logic [INT_W-1:0] s2_norm_q,  s2_norm_d;
    logic [8:0]       s2_exp_q,   s2_exp_d;
    logic             s2_zero_q,  s2_zero_d;
    logic [1:0]       s2_rm_q;
    logic [LZW-1:0]   lz_d;
    logic             lz_found;

    // Stage 3 (output) registers
    logic             out_valid_q;
    logic [31:0]      fp_q,       fp_d;
    logic             inexact_q,  inexact_d;

    // Rounding datapath
    logic [INT_W+23:0] ext;
    logic [22:0]       frac;
    logic              g_bit;
    logic              s_bit;
    logic              round_up;
    logic [23:0]       frac_sum;
    logic [8:0]        exp_r;
    logic [22:0]       frac_r;
    logic [1:0]        unused_bits;

    assign adv      = !out_valid_q | out_ready;
    assign in_ready = adv;

    assign out_valid = out_valid_q;
    assign FP_out    = fp_q;
    assign inexact   = inexact_q;

    // Stage 1 combinational: extract sign and two's complement magnitude
    always_comb begin
        s1_sign_d = is_signed & int_in[INT_W-1];
        s1_mag_d  = s1_sign_d ? -int_in : int_in;
    end

    // Stage 2 combinational: leading-zero count, normalise, exponent
    always_comb begin
        lz_d     = '0;
        lz_found = 1'b0;
        for (int i = INT_W - 1; i >= 0; i--) begin
            if (!lz_found && s1_mag_q[i]) begin
                lz_found = 1'b1;
                lz_d     = LZW'(INT_W - 1 - i);
            end
        end
        s2_norm_d = s1_mag_q << lz_d;
        s2_exp_d  = 9'(127 + INT_W - 1 - int'(lz_d));
        s2_zero_d = (s1_mag_q == '0);
    end

    // Stage 3 combinational: guard/sticky, mode-dependent rounding, pack
    always_comb begin
        // Padding below the magnitude makes frac/G/S extraction uniform for narrow INT_W
        ext    = {s2_norm_q, 24'b0};
        frac   = ext[INT_W+22 -: 23];
        g_bit  = ext[INT_W-1];
        s_bit  = |ext[INT_W-2:0];
        case (s2_rm_q)
            RM_RNE:  round_up = g_bit & (s_bit | frac[0]);
            RM_RTZ:  round_up = 1'b0;
            RM_POS:  round_up = (g_bit | s_bit) & !s2_sign_q;
            RM_NEG:  round_up = (g_bit | s_bit) & s2_sign_q;
            default: round_up = 1'b0;
        endcase
        frac_sum = {1'b0, frac} + {23'b0, round_up};
        // Carry out of the fraction means the mantissa became 2.0: bump exponent
        if (frac_sum[23]) begin
            exp_r  = s2_exp_q + 9'd1;
            frac_r = 23'b0;
        end else begin
            exp_r  = s2_exp_q;
            frac_r = frac_sum[22:0];
        end
        if (s2_zero_q) begin
            fp_d      = 32'h0000_0000;
            inexact_d = 1'b0;
        end else begin
            fp_d      = {s2_sign_q, exp_r[7:0], frac_r};
            inexact_d = g_bit | s_bit;
        end
        // Exponent never exceeds 8 bits for legal INT_W; hidden bit is implicit
        unused_bits = {exp_r[8], ext[INT_W+23]};
    end

    // Stage 1 register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
            s1_rm_q    <= 2'b00;
        end else if (adv) begin
            s1_valid_q <= in_valid & in_ready;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
            s1_rm_q    <= round_mode;
        end
    end

    // Stage 2 register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_norm_q  <= '0;
            s2_exp_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_rm_q    <= 2'b00;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_q;
            s2_norm_q  <= s2_norm_d;
            s2_exp_q   <= s2_exp_d;
            s2_zero_q  <= s2_zero_d;
            s2_rm_q    <= s1_rm_q;
        end
    end

    // Output register: holds result while downstream stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            fp_q        <= 32'h0000_0000;
            inexact_q   <= 1'b0;
        end else if (adv) begin
            out_valid_q <= s2_valid_q;
            fp_q        <= fp_d;
            inexact_q   <= inexact_d;
        end
    end

endmodule

// File: tb/tb_int_to_fp_converter.sv
// Bench for int_to_fp_converter: directed spec cases, stall, reset, random stream.
module tb_int_to_fp_converter;

  localparam int INT_W = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [INT_W-1:0] int_in;
  logic             is_signed;
  logic [1:0]       round_mode;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      FP_out;
  logic             inexact;
  logic             out_valid;
  logic             out_ready;

  int errors = 0;
  int checks = 0;
  int outputs_seen = 0;
  logic [32:0] exp_q[$];

  int_to_fp_converter #(.INT_W(INT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .int_in     (int_in),
    .is_signed  (is_signed),
    .round_mode (round_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .FP_out     (FP_out),
    .inexact    (inexact),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: real-number view of rounding. Returns {inexact, fp32}.
  function automatic logic [32:0] model(input logic [31:0] x, input logic sg, input logic [1:0] rm);
    logic [63:0] m, q, rem, half;
    logic        s, up;
    int          e;
    logic [7:0]  ev;
    s = sg & x[31];
    m = s ? (64'h1_0000_0000 - {32'b0, x}) : {32'b0, x};
    if (m == 64'd0) return 33'b0;
    e = 0;
    for (int i = 0; i < 64; i++) if (m >= (64'd1 << i)) e = i;
    if (e <= 23) begin
      q = m << (23 - e);
      rem = 64'd0;
      half = 64'd0;
    end else begin
      q = m >> (e - 23);
      rem = m - (q << (e - 23));
      half = 64'd1 << (e - 24);
    end
    case (rm)
      2'd0: up = (rem > half) || (rem == half && rem != 0 && q[0]);
      2'd1: up = 1'b0;
      2'd2: up = (rem != 0) && !s;
      default: up = (rem != 0) && s;
    endcase
    q = q + {63'b0, up};
    if (q[24]) begin
      q = q >> 1;
      e = e + 1;
    end
    ev = 8'(e + 127);
    return {rem != 0, s, ev, q[22:0]};
  endfunction

  // scoreboard monitor: compare on each output transfer, check hold under stall
  logic        hold_prev = 1'b0;
  logic [32:0] prev_out;
  logic [32:0] exp_v;
  always @(negedge clk) begin
    if (!reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", {63'b0, out_valid}, 64'd1);
        check("hold_data", {31'b0, inexact, FP_out}, {31'b0, prev_out});
      end
      if (out_valid && out_ready) begin
        outputs_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h with no expected entry", {inexact, FP_out});
        end else begin
          exp_v = exp_q.pop_front();
          check("result", {31'b0, inexact, FP_out}, {31'b0, exp_v});
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_out  = {inexact, FP_out};
    end
  end

  // driver tasks
  task automatic send(input logic [31:0] x, input logic sg, input logic [1:0] rm,
                      input logic [32:0] expv, input bit track);
    int budget = 0;
    int_in = x;
    is_signed = sg;
    round_mode = rm;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && budget < 200) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at %0d, required 1", in_ready);
    end else if (track) begin
      exp_q.push_back(expv);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    int_in = $urandom;
    is_signed = 1'(($urandom_range(0, 1)));
    round_mode = 2'($urandom_range(0, 3));
  endtask

  task automatic send_m(input logic [31:0] x, input logic sg, input logic [1:0] rm);
    send(x, sg, rm, model(x, sg, rm), 1'b1);
  endtask

  // send into an empty pipeline and measure edges until out_valid
  task automatic send_lat(input logic [31:0] x, input logic sg, input logic [1:0] rm,
                          input logic [32:0] expv);
    int n = 0;
    send(x, sg, rm, expv, 1'b1);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'd3);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 500) begin
      @(posedge clk);
      b++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0: v = $urandom;
      1: v = 32'($urandom_range(0, 255));
      2: v = 32'd1 << $urandom_range(0, 31);
      3: v = $urandom | 32'h8000_0000;
      default: v = (32'd1 << $urandom_range(24, 31)) | 32'($urandom_range(0, 3));
    endcase
    return v;
  endfunction

  bit rnd_done = 1'b0;
  int seen_before;

  initial begin
    in_valid = 1'b0;
    out_ready = 1'b1;
    int_in = '0;
    is_signed = 1'b0;
    round_mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_fp_out", {32'b0, FP_out}, 64'd0);
    check("reset_inexact", {63'b0, inexact}, 64'd0);
    check("reset_in_ready", {63'b0, in_ready}, 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // +1 / -1 with latency
    send_lat(32'd1, 1'b1, 2'd0, {1'b0, 32'h3F80_0000});
    send_lat(32'hFFFF_FFFF, 1'b1, 2'd0, {1'b0, 32'hBF80_0000});

    // directed rounding cases, back-to-back
    send(32'h7FFF_FFFF, 1'b1, 2'd0, {1'b1, 32'h4F00_0000}, 1'b1);
    send(32'h7FFF_FFFF, 1'b1, 2'd1, {1'b1, 32'h4EFF_FFFF}, 1'b1);
    send(32'hFFFF_FFFF, 1'b0, 2'd0, {1'b1, 32'h4F80_0000}, 1'b1);
    for (int m = 0; m < 4; m++)
      send(32'h8000_0000, 1'b1, 2'(m), {1'b0, 32'hCF00_0000}, 1'b1);
    send(32'h0100_0001, 1'b1, 2'd0, {1'b1, 32'h4B80_0000}, 1'b1);
    send(32'h0100_0001, 1'b1, 2'd1, {1'b1, 32'h4B80_0000}, 1'b1);
    send(32'h0100_0001, 1'b1, 2'd2, {1'b1, 32'h4B80_0001}, 1'b1);
    send(32'h0100_0001, 1'b1, 2'd3, {1'b1, 32'h4B80_0000}, 1'b1);
    for (int m = 0; m < 8; m++)
      send(32'h0, 1'(m / 4), 2'(m % 4), 33'h0, 1'b1);
    drain();

    // stall: 6 back-to-back inputs while output is blocked for 5 cycles
    seen_before = outputs_seen;
    fork
      begin
        for (int k = 0; k < 6; k++)
          send_m(rand_val(), 1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)));
      end
      begin
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("stall_out_valid", {63'b0, out_valid}, 64'd1);
        check("stall_in_ready", {63'b0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_count", 64'(outputs_seen - seen_before), 64'd6);

    // reset with two operations in flight
    out_ready = 1'b0;
    send(32'd5, 1'b1, 2'd0, 33'h0, 1'b0);
    send(32'd7, 1'b1, 2'd0, 33'h0, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("async_reset_fp_out", {32'b0, FP_out}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_lat(32'd2, 1'b1, 2'd0, {1'b0, 32'h4000_0000});
    drain();

    // random stream with random backpressure and input gaps
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          send_m(rand_val(), 1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)));
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
